// File: rtl/pin_host_pkg.sv
// Shared definitions for the tt_um_top pin-interface host sequencer:
// op codes, pin control codes, FSM states and pin bit positions.
package pin_host_pkg;

  typedef enum logic [1:0] {
    OP_ADD   = 2'd0,
    OP_LATCH = 2'd1,
    OP_VGA   = 2'd2,
    OP_CAM   = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    CTRL_ADD   = 2'b00,
    CTRL_LATCH = 2'b01,
    CTRL_VGA   = 2'b10,
    CTRL_CAM   = 2'b11
  } ctrl_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam int CTRL_HI = 7;
  localparam int CTRL_LO = 6;
  localparam int CAM_WR  = 5;

  localparam logic [7:0] VGA_UI = 8'h80;

  // VGA and CAM go through registered paths inside the target and need the longer settle time.
  function automatic logic is_seq_op(input logic [1:0] op);
    return (op == OP_VGA) || (op == OP_CAM);
  endfunction

endpackage

// File: rtl/pin_host_seq_if.sv
// Command and response valid/ready channels between a harness driver
// (master) and the pin host sequencer (slave).
interface pin_host_seq_if;

  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic       cmd_wr;
  logic [5:0] cmd_a;
  logic [7:0] cmd_b;

  logic       rsp_valid;
  logic       rsp_ready;
  logic [1:0] rsp_op;
  logic [7:0] rsp_data;

  modport master (
    output cmd_valid, cmd_op, cmd_wr, cmd_a, cmd_b, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_op, rsp_data
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_wr, cmd_a, cmd_b, rsp_ready,
    output cmd_ready, rsp_valid, rsp_op, rsp_data
  );

endinterface

// File: rtl/pin_image_enc.sv
// Maps a host command onto the ui_in/uio_in image expected by tt_um_top.
// Purely combinational; the sequencer registers the result on acceptance.
module pin_image_enc
  import pin_host_pkg::*;
(
  input  logic [1:0] op,
  input  logic       wr,
  input  logic [5:0] a,
  input  logic [7:0] b,
  output logic [7:0] ui,
  output logic [7:0] uio
);

  always_comb begin
    ui  = '0;
    uio = '0;
    case (op)
      OP_ADD: begin
        ui  = {CTRL_ADD, a};
        uio = b;
      end
      OP_LATCH: begin
        ui  = {CTRL_LATCH, a};
        uio = b;
      end
      OP_VGA: begin
        ui  = VGA_UI;
        uio = 8'h00;
      end
      default: begin
        // a[5] has no meaning for CAM; bit 5 carries the write strobe instead.
        ui  = {CTRL_CAM, wr, a[4:0]};
        uio = b;
      end
    endcase
  end

endmodule

// File: rtl/pin_host_seq.sv
// Host-side initiator for the multiplexed tt_um_top pins: accepts a command,
// drives the pin image, waits a fixed settle time and returns uo_out.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | ready for a command; pins hold the previous image
// ST_WAIT | pins driven, settle counter running down to 0
// ST_RESP | captured uo_out presented, waiting for rsp_ready
module pin_host_seq
  import pin_host_pkg::*;
#(
  parameter int WAIT_COMB = 1,
  parameter int WAIT_SEQ  = 3
) (
  input  logic           clk,
  input  logic           rst_n,
  pin_host_seq_if.slave  bus,
  output logic [7:0]     dut_ui_in,
  output logic [7:0]     dut_uio_in,
  input  logic [7:0]     dut_uo_out,
  output logic           busy
);

  if (WAIT_COMB < 1 || WAIT_COMB > 4) begin : g_bad_wait_comb
    $error("pin_host_seq: WAIT_COMB must be in 1..4");
  end
  if (WAIT_SEQ < 2 || WAIT_SEQ > 4) begin : g_bad_wait_seq
    $error("pin_host_seq: WAIT_SEQ must be in 2..4");
  end

  localparam logic [1:0] CNT_COMB = 2'(WAIT_COMB - 1);
  localparam logic [1:0] CNT_SEQ  = 2'(WAIT_SEQ - 1);

  state_e     state_q, state_d;
  logic [1:0] cnt_q;
  logic [1:0] op_q;
  logic       accept;
  logic       capture;
  logic       rsp_valid_q;
  logic [1:0] rsp_op_q;
  logic [7:0] rsp_data_q;
  logic [7:0] enc_ui;
  logic [7:0] enc_uio;

  pin_image_enc u_enc (
    .op  (bus.cmd_op),
    .wr  (bus.cmd_wr),
    .a   (bus.cmd_a),
    .b   (bus.cmd_b),
    .ui  (enc_ui),
    .uio (enc_uio)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    capture = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.cmd_valid) begin
          accept  = 1'b1;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q == 2'd0) begin
          capture = 1'b1;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (bus.rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      op_q       <= '0;
      dut_ui_in  <= '0;
      dut_uio_in <= '0;
    end else if (accept) begin
      cnt_q      <= is_seq_op(bus.cmd_op) ? CNT_SEQ : CNT_COMB;
      op_q       <= bus.cmd_op;
      dut_ui_in  <= enc_ui;
      dut_uio_in <= enc_uio;
    end else if (state_q == ST_WAIT) begin
      if (cnt_q != 2'd0) begin
        cnt_q <= cnt_q - 2'd1;
      end
      // Bit 5 is the CAM write strobe only; for ADD/LATCH it is operand data.
      if (dut_ui_in[CTRL_HI:CTRL_LO] == CTRL_CAM) begin
        dut_ui_in[CAM_WR] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= 1'b0;
      rsp_op_q    <= '0;
      rsp_data_q  <= '0;
    end else if (capture) begin
      rsp_valid_q <= 1'b1;
      rsp_op_q    <= op_q;
      rsp_data_q  <= dut_uo_out;
    end else if (state_q == ST_RESP && bus.rsp_ready) begin
      rsp_valid_q <= 1'b0;
    end
  end

  assign bus.cmd_ready = (state_q == ST_IDLE);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_op    = rsp_op_q;
  assign bus.rsp_data  = rsp_data_q;
  assign busy          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_pin_host_seq.sv
// Bench for pin_host_seq: a behavioural stand-in for tt_um_top on the pins,
// directed cases followed by random commands against a command-level model.
module tb_pin_host_seq;
  import pin_host_pkg::*;

  localparam int WC = 1;
  localparam int WS = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] dut_ui_in;
  logic [7:0] dut_uio_in;
  logic [7:0] fake_uo;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int unsigned cyc = 0;

  pin_host_seq_if bus ();

  pin_host_seq #(
    .WAIT_COMB (WC),
    .WAIT_SEQ  (WS)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .dut_ui_in  (dut_ui_in),
    .dut_uio_in (dut_uio_in),
    .dut_uo_out (fake_uo),
    .busy       (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Stand-in target: adder, latch view, VGA counter and a 32-entry CAM written by the strobe.
  logic [7:0]  cam_mem [32];
  logic [31:0] cam_vld = '0;
  logic [7:0]  cam_hit;

  always @(posedge clk) begin
    if (dut_ui_in[7:6] == 2'b11 && dut_ui_in[5]) begin
      cam_mem[dut_ui_in[4:0]] <= dut_uio_in;
      cam_vld[dut_ui_in[4:0]] <= 1'b1;
    end
  end

  always_comb begin
    cam_hit = 8'h00;
    for (int i = 31; i >= 0; i--) begin
      if (cam_vld[i] && cam_mem[i] == dut_uio_in) cam_hit = {3'b000, 1'b1, 4'(i)};
    end
  end

  always_comb begin
    case (dut_ui_in[7:6])
      2'b00:   fake_uo = 8'(dut_ui_in[5:0]) + 8'(dut_uio_in[5:0]) + 8'(dut_uio_in[7]);
      2'b01:   fake_uo = {dut_ui_in[3:0], dut_uio_in[3:0]};
      2'b10:   fake_uo = cyc[7:0];
      default: fake_uo = cam_hit;
    endcase
  end

  // Reference CAM contents, updated per completed write command.
  logic [7:0]  ref_mem [32];
  logic [31:0] ref_vld = '0;

  function automatic logic [7:0] ref_search(input logic [7:0] key);
    for (int i = 0; i < 32; i++) begin
      if (ref_vld[i] && ref_mem[i] == key) return {3'b000, 1'b1, 4'(i)};
    end
    return 8'h00;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_cmd(input logic [1:0] op, input logic wr, input logic [5:0] a,
                        input logic [7:0] b, input int hold);
    logic [7:0] eui, euio, eui_held, edata;
    int w, lat;
    int unsigned acc;
    case (op)
      2'd0:    begin eui = {2'b00, a};           euio = b;     end
      2'd1:    begin eui = {2'b01, a};           euio = b;     end
      2'd2:    begin eui = 8'h80;                euio = 8'h00; end
      default: begin eui = {2'b11, wr, a[4:0]};  euio = b;     end
    endcase
    eui_held = eui;
    if (op == 2'd3) eui_held[5] = 1'b0;
    w = (op < 2'd2) ? WC : WS;

    bus.cmd_op = op; bus.cmd_wr = wr; bus.cmd_a = a; bus.cmd_b = b;
    bus.cmd_valid = 1'b1;
    lat = 0;
    while (!bus.cmd_ready && lat < 20) begin tick(); lat++; end
    chk("cmd_ready_idle", bus.cmd_ready, 1);
    tick();
    bus.cmd_valid = 1'b0;
    acc = cyc;
    chk("accept_busy", busy, 1);
    chk("ui_at_accept", dut_ui_in, eui);
    chk("uio_at_accept", dut_uio_in, euio);

    if (op == 2'd3 && wr) begin
      ref_mem[a[4:0]] = b;
      ref_vld[a[4:0]] = 1'b1;
    end
    case (op)
      2'd0:    edata = 8'({2'b00, a}) + 8'(b[5:0]) + 8'(b[7]);
      2'd1:    edata = {a[3:0], b[3:0]};
      2'd2:    edata = 8'(acc - 1 + w);
      default: edata = ref_search(b);
    endcase

    lat = 0;
    while (!bus.rsp_valid && lat < 16) begin
      tick();
      lat++;
      if (lat == 1) chk("ui_after_strobe", dut_ui_in, eui_held);
    end
    chk("rsp_latency", lat, w);
    chk("rsp_op", bus.rsp_op, op);
    chk("rsp_data", bus.rsp_data, edata);

    for (int i = 0; i < hold; i++) begin
      bus.cmd_op = 2'($urandom_range(0, 3));
      bus.cmd_valid = 1'b1;
      tick();
      chk("bp_rsp_valid", bus.rsp_valid, 1);
      chk("bp_rsp_data", bus.rsp_data, edata);
      chk("bp_cmd_ready", bus.cmd_ready, 0);
    end
    bus.cmd_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    chk("rsp_cleared", bus.rsp_valid, 0);
    chk("idle_ready", bus.cmd_ready, 1);
    chk("idle_busy", busy, 0);
    chk("pins_held", {dut_ui_in, dut_uio_in}, {eui_held, euio});
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout got=%0d exp=finish", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    logic seen;
    bus.cmd_valid = 1'b0; bus.cmd_op = '0; bus.cmd_wr = 1'b0;
    bus.cmd_a = '0; bus.cmd_b = '0; bus.rsp_ready = 1'b0;

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cmd_ready", bus.cmd_ready, 1);
    rst_n = 1'b1;
    tick();
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rsp_op", bus.rsp_op, 0);
    chk("rst_rsp_data", bus.rsp_data, 0);
    chk("rst_ui", dut_ui_in, 0);
    chk("rst_uio", dut_uio_in, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready_after", bus.cmd_ready, 1);

    do_cmd(OP_ADD, 1'b0, 6'd37, 8'h9A, 0);
    chk("add_example_sum", bus.rsp_data, 8'd64);
    do_cmd(OP_CAM, 1'b1, 6'd5, 8'hA5, 0);
    do_cmd(OP_CAM, 1'b0, 6'd5, 8'hA5, 1);
    chk("cam_found_addr5", bus.rsp_data, 8'h15);
    do_cmd(OP_CAM, 1'b0, 6'd0, 8'h3C, 0);
    chk("cam_miss_found", bus.rsp_data[4], 0);
    do_cmd(OP_VGA, 1'b0, 6'd0, 8'h00, 2);
    do_cmd(OP_LATCH, 1'b0, 6'h2B, 8'h7E, 0);
    do_cmd(OP_ADD, 1'b0, 6'h3F, 8'hFF, 10);

    // Reset while the settle counter is still running.
    bus.cmd_op = OP_VGA; bus.cmd_wr = 1'b0; bus.cmd_a = '0; bus.cmd_b = '0;
    bus.cmd_valid = 1'b1;
    tick();
    bus.cmd_valid = 1'b0;
    chk("mid_accept_busy", busy, 1);
    tick();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ui", dut_ui_in, 0);
    chk("mid_rst_uio", dut_uio_in, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_rsp_valid", bus.rsp_valid, 0);
    tick();
    tick();
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      tick();
      if (bus.rsp_valid) seen = 1'b1;
    end
    chk("no_rsp_after_rst", seen, 0);
    do_cmd(OP_ADD, 1'b0, 6'd12, 8'h05, 0);

    for (int n = 0; n < 40; n++) begin
      logic [1:0] op;
      logic [7:0] b;
      op = 2'($urandom_range(0, 3));
      b  = (op == OP_CAM) ? 8'($urandom_range(0, 7)) : 8'($urandom);
      do_cmd(op, 1'($urandom_range(0, 1)), 6'($urandom), b, $urandom_range(0, 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
